// File: rtl/adc_rx_demod.sv
// Coherent I/Q demodulator: per-lane multiply, integrate-and-dump, round, saturate; last sample -> iqpcm_valid in 3 cycles.
// No backpressure: every qualified sample is consumed; results are a one-cycle pulse that the consumer must take.
module adc_rx_demod #(
   parameter int FREQ_NUM  = 6,
   parameter int ACC_W     = 48,
   parameter int OUT_SHIFT = 15
) (
   input  logic                    ad_clk,
   input  logic                    rst,
   input  logic [15:0]             adc_pcm_in,
   input  logic                    adc_pcm_valid,
   input  logic [16*FREQ_NUM-1:0]  ref_cos,
   input  logic [16*FREQ_NUM-1:0]  ref_sin,
   input  logic                    en,
   input  logic [15:0]             dump_len,
   output logic [16*FREQ_NUM-1:0]  ipcm_out,
   output logic [16*FREQ_NUM-1:0]  qpcm_out,
   output logic                    iqpcm_valid,
   input  logic                    err_clr,
   output logic                    err
);

   typedef enum logic {IDLE, RUN} state_t;

   localparam logic signed [ACC_W-1:0] RND  = ACC_W'(1) << (OUT_SHIFT - 1);
   localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(32767);
   localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-32768);

   state_t      state;
   logic [16:0] win_len;
   logic [16:0] cnt;
   logic [16:0] dl_eff;
   logic [16:0] cur_len;
   logic        accept;
   logic        flush;
   logic        first;
   logic        last;

   logic signed [15:0]      adc_s;
   logic signed [15:0]      cos_k [FREQ_NUM];
   logic signed [15:0]      sin_k [FREQ_NUM];
   logic signed [31:0]      s1_pi [FREQ_NUM];
   logic signed [31:0]      s1_pq [FREQ_NUM];
   logic                    s1_vld;
   logic                    s1_first;
   logic                    s1_last;
   logic signed [ACC_W-1:0] acc_i [FREQ_NUM];
   logic signed [ACC_W-1:0] acc_q [FREQ_NUM];
   logic                    s2_last;
   logic signed [ACC_W-1:0] rnd_i [FREQ_NUM];
   logic signed [ACC_W-1:0] rnd_q [FREQ_NUM];
   logic [FREQ_NUM-1:0]     sat_i;
   logic [FREQ_NUM-1:0]     sat_q;
   logic [16*FREQ_NUM-1:0]  res_i;
   logic [16*FREQ_NUM-1:0]  res_q;

   assign adc_s = adc_pcm_in;

   always_comb begin
      flush   = (state == RUN) && !en;
      accept  = (state == RUN) && en && adc_pcm_valid;
      first   = (cnt == 17'd0);
      dl_eff  = (dump_len == 16'd0) ? 17'h10000 : {1'b0, dump_len};
      // The window length is taken from dump_len on the first sample itself.
      cur_len = first ? dl_eff : win_len;
      last    = ((cnt + 17'd1) == cur_len);
   end

   always_comb begin
      res_i = '0;
      res_q = '0;
      sat_i = '0;
      sat_q = '0;
      for (int k = 0; k < FREQ_NUM; k++) begin
         cos_k[k] = ref_cos[16*k +: 16];
         sin_k[k] = ref_sin[16*k +: 16];
         rnd_i[k] = (acc_i[k] + RND) >>> OUT_SHIFT;
         rnd_q[k] = (acc_q[k] + RND) >>> OUT_SHIFT;
         sat_i[k] = (rnd_i[k] > MAXV) || (rnd_i[k] < MINV);
         sat_q[k] = (rnd_q[k] > MAXV) || (rnd_q[k] < MINV);
         res_i[16*k +: 16] = (rnd_i[k] > MAXV) ? 16'h7fff :
                             (rnd_i[k] < MINV) ? 16'h8000 : rnd_i[k][15:0];
         res_q[16*k +: 16] = (rnd_q[k] > MAXV) ? 16'h7fff :
                             (rnd_q[k] < MINV) ? 16'h8000 : rnd_q[k][15:0];
      end
   end

   always_ff @(posedge ad_clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         win_len <= '0;
         cnt     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (en) begin
                  state   <= RUN;
                  win_len <= dl_eff;
                  cnt     <= '0;
               end
            end
            RUN: begin
               if (!en) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (accept) begin
                  win_len <= cur_len;
                  cnt     <= last ? 17'd0 : cnt + 17'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge ad_clk or posedge rst) begin
      if (rst) begin
         s1_vld      <= 1'b0;
         s1_first    <= 1'b0;
         s1_last     <= 1'b0;
         s2_last     <= 1'b0;
         iqpcm_valid <= 1'b0;
         err         <= 1'b0;
         ipcm_out    <= '0;
         qpcm_out    <= '0;
         for (int k = 0; k < FREQ_NUM; k++) begin
            s1_pi[k] <= '0;
            s1_pq[k] <= '0;
            acc_i[k] <= '0;
            acc_q[k] <= '0;
         end
      end else begin
         s1_vld   <= accept;
         s1_first <= first;
         s1_last  <= last;
         if (accept) begin
            for (int k = 0; k < FREQ_NUM; k++) begin
               s1_pi[k] <= 32'(adc_s) * 32'(cos_k[k]);
               s1_pq[k] <= 32'(adc_s) * 32'(sin_k[k]);
            end
         end

         // Dropping en kills everything still in flight, including a finished window.
         s2_last <= s1_vld && s1_last && !flush;
         if (s1_vld && !flush) begin
            for (int k = 0; k < FREQ_NUM; k++) begin
               acc_i[k] <= s1_first ? ACC_W'(s1_pi[k]) : acc_i[k] + ACC_W'(s1_pi[k]);
               acc_q[k] <= s1_first ? ACC_W'(s1_pq[k]) : acc_q[k] + ACC_W'(s1_pq[k]);
            end
         end

         iqpcm_valid <= s2_last && !flush;
         if (s2_last && !flush) begin
            ipcm_out <= res_i;
            qpcm_out <= res_q;
         end

         if (s2_last && !flush && (|{sat_i, sat_q}))
            err <= 1'b1;
         else if (err_clr)
            err <= 1'b0;
      end
   end

endmodule
